i2s_mic_capture_ctrl: RTL and testbench
=======================================

// Module: i2s_mic_capture_ctrl
// PURPOSE
//  I2S master sequencer for the 4-line MEMS mic array. Runs on the PLL bit clock (sck), drives ws,
//  samples sd lines, and deserializes samples per slot. Queues samples in a FIFO and presents them as a
//  valid/ready stream to the Avalon-side sample reader. Tracks dropped samples.
// PARAMETERS
//  SAMPLE_W    24  bits captured per slot, MSB first, SAMPLE_W <= SLOT_W-1
//  SLOT_W      32  sck cycles per ws half-period; frame = 2*SLOT_W cycles
//  NUM_LINES   4   sd input lines (one stereo mic pair per line)
//  FIFO_DEPTH  16  sample FIFO entries, power of 2
// PORTS
//  clk        in   1                      I2S bit clock (sck); the only clock
//  reset      in   1                      asynchronous, active-high
//  en         in   1                      run request
//  sd         in   NUM_LINES              serial data; mic drives on sck fall, sampled on rise
//  ws         out  1                      word select: 0 = left slot, 1 = right slot
//  busy       out  1                      frame sequencing active
//  s_data     out  SAMPLE_W               FIFO head sample (show-ahead)
//  s_chan     out  $clog2(NUM_LINES)+1    {line index, lr}; lr = 1 for right slot
//  s_valid    out  1                      FIFO non-empty
//  s_ready    in   1                      consumer accepts when s_valid && s_ready
//  clr_ovf    in   1                      clears ovf and ovf_cnt
//  ovf        out  1                      sticky: at least one sample dropped
//  ovf_cnt    out  16                     dropped-sample count, saturates at 16'hFFFF
// BEHAVIOUR
//  - Reset (async, takes effect immediately): ws=0, busy=0, s_valid=0, s_data=0, s_chan=0, ovf=0,
//    ovf_cnt=0, bit_cnt=0, FIFO empty, push sequencer IDLE.
//  - Sequencer states: STOP, RUN.
//    - STOP->RUN when en=1. The next cycle has bit_cnt=0.
//    - In RUN, bit_cnt increments 0..2*SLOT_W-1 and wraps.
//    - RUN->STOP only at bit_cnt=2*SLOT_W-1 with en=0. Frames always complete.
//    - busy=1 in RUN.
//  - ws is registered. In the cycle with bit_cnt=k, ws = (k >= SLOT_W). In STOP, ws=0 and bit_cnt=0.
//  - Capture (I2S one-bit delay): the sd bit sampled when (bit_cnt mod SLOT_W) = j, for j = 1..SAMPLE_W,
//    is sample bit SAMPLE_W-j. Bit 0 and bits above SAMPLE_W are ignored.
//  - At (bit_cnt mod SLOT_W) = SAMPLE_W, all NUM_LINES completed words, including the current bit, load
//    a hold register.
//  - Push sequencer states: IDLE, PUSH.
//    - The next NUM_LINES cycles push line 0..NUM_LINES-1, one per cycle, with s_chan = {line, ws_of_slot}.
//    - Then return to IDLE. This completes well before the next slot load.
//  - FIFO full check uses the registered count. A push while count = FIFO_DEPTH is dropped even if a pop
//    happens in the same cycle. A drop sets ovf and increments ovf_cnt (saturating).
//    - Simultaneous pop and push when not full: count unchanged.
//  - Pop on s_valid && s_ready. s_data/s_chan update the cycle after a pop. s_ready while !s_valid is ignored.
//  - clr_ovf together with a drop in the same cycle: clear wins, then ovf=1 and ovf_cnt=1.
//  - en does not flush the FIFO. Samples remain poppable in STOP.
// CONFIGURATION
//  MIC_STEREO_EN defined: left and right slots are both captured (2*NUM_LINES samples per frame).
//  MIC_STEREO_EN undefined:
//    - Only the left slot is captured (NUM_LINES samples per frame). s_chan lr bit is always 0.
//    - ws timing is unchanged.
// STRUCTURE
//  Package i2s_pkg:
//    - SAMPLE_W/SLOT_W/NUM_LINES defaults
//    - sample_t (logic [SAMPLE_W-1:0])
//    - chan_t
//    - seq_state_e {STOP, RUN}
//    - push_state_e {IDLE, PUSH}
//  Sub-module i2s_sample_fifo: synchronous FIFO with show-ahead, FIFO_DEPTH x {chan_t, sample_t},
//  count/full/empty. Everything else lives in this module.
// TESTING
//  1. Reset, en=1, stereo.
//     - Stimulus: line n sends left 24'hA00000+n, right 24'h500000+n.
//     - Expect pop order chan 0,2,4,6 (left), then 1,3,5,7 (right), with matching data.
//  2. en=1 free-running.
//     - Expect ws low for 32 clk, high for 32 clk, period 64.
//     - Expect the first left push 25 clk after bit_cnt=0, i.e. at bit_cnt 25..28.
//  3. s_ready=0, stereo.
//     - Expect FIFO full (16) after 2 frames.
//     - Expect frame 3 to drop 8: ovf=1, ovf_cnt=8.
//     - clr_ovf pulse -> ovf=0, ovf_cnt=0.
//  4. FIFO at 16 with s_ready=1 during a push cycle.
//     - Expect that push dropped (ovf_cnt+1) and the head popped; count 15.
//  5. en dropped at bit_cnt=10.
//     - Expect the frame to complete, busy=0 after bit_cnt=63, ws=0, and all 8 samples queued.
//  6. Async reset asserted at bit_cnt=40 with FIFO holding 5.
//     - Expect s_valid=0, ws=0, busy=0, ovf_cnt=0 before the next clk edge.
//  7. MIC_STEREO_EN undefined: scenario 1 yields only chans 0,2,4,6 per frame.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared defaults, sample/channel types and state encodings for the I2S mic capture slice.
package i2s_pkg;

    localparam int DEF_SAMPLE_W   = 24;
    localparam int DEF_SLOT_W     = 32;
    localparam int DEF_NUM_LINES  = 4;
    localparam int DEF_FIFO_DEPTH = 16;

    typedef logic [DEF_SAMPLE_W-1:0]         sample_t;
    typedef logic [$clog2(DEF_NUM_LINES):0]  chan_t;

    typedef enum logic {STOP = 1'b0, RUN  = 1'b1} seq_state_e;
    typedef enum logic {IDLE = 1'b0, PUSH = 1'b1} push_state_e;

endpackage

// File: rtl/i2s_sample_fifo.sv
// Show-ahead synchronous FIFO; full/empty come from the registered count, so a push
// into a full FIFO is refused even when a pop happens in the same cycle.
module i2s_sample_fifo #(
    parameter int WIDTH = 29,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = empty_o ? '0 : mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/i2s_mic_capture_ctrl.sv
// I2S master frame sequencer, per-line deserializer and sample FIFO front end.
// Define MIC_STEREO_EN to capture both slots; otherwise only the left slot is queued.
module i2s_mic_capture_ctrl
    import i2s_pkg::*;
#(
    parameter int SAMPLE_W   = DEF_SAMPLE_W,
    parameter int SLOT_W     = DEF_SLOT_W,
    parameter int NUM_LINES  = DEF_NUM_LINES,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic [NUM_LINES-1:0]         sd,
    output logic                         ws,
    output logic                         busy,
    output logic [SAMPLE_W-1:0]          s_data,
    output logic [$clog2(NUM_LINES):0]   s_chan,
    output logic                         s_valid,
    input  logic                         s_ready,
    input  logic                         clr_ovf,
    output logic                         ovf,
    output logic [15:0]                  ovf_cnt
);

    localparam int CNT_W  = $clog2(2*SLOT_W);
    localparam int LINE_W = $clog2(NUM_LINES);
    localparam int CHAN_W = LINE_W + 1;

    seq_state_e          seq_q, seq_d;
    push_state_e         push_q, push_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic                ws_q, ws_d;
    logic [CNT_W-1:0]    slot_pos;
    logic                shift_en, load, cap_slot, slot_lr;
    logic [SAMPLE_W-2:0] shift_q [NUM_LINES];
    logic [SAMPLE_W-1:0] hold_q  [NUM_LINES];
    logic                hold_lr_q;
    logic [LINE_W-1:0]   line_q, line_d;
    logic                push_req, pop, fifo_full, fifo_empty, drop;
    logic [CHAN_W+SAMPLE_W-1:0] push_data, head;
    logic                ovf_q, ovf_d;
    logic [15:0]         ovf_cnt_q, ovf_cnt_d;

`ifdef MIC_STEREO_EN
    assign cap_slot = 1'b1;
    assign slot_lr  = ws_q;
`else
    assign cap_slot = ~ws_q;
    assign slot_lr  = 1'b0;
`endif

    always_comb begin
        seq_d     = seq_q;
        bit_cnt_d = bit_cnt_q;
        case (seq_q)
            STOP: begin
                bit_cnt_d = '0;
                if (en) seq_d = RUN;
            end
            default: begin
                if (bit_cnt_q == CNT_W'(2*SLOT_W-1)) begin
                    bit_cnt_d = '0;
                    if (!en) seq_d = STOP;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
        endcase
        // ws is registered, so derive it from the count the next cycle will hold
        ws_d = (seq_d == RUN) && (bit_cnt_d >= CNT_W'(SLOT_W));
    end

    assign slot_pos = (bit_cnt_q >= CNT_W'(SLOT_W)) ? bit_cnt_q - CNT_W'(SLOT_W) : bit_cnt_q;
    assign shift_en = (seq_q == RUN) && (slot_pos != '0) && (slot_pos <= CNT_W'(SAMPLE_W));
    assign load     = (seq_q == RUN) && (slot_pos == CNT_W'(SAMPLE_W)) && cap_slot;

    always_comb begin
        push_d = push_q;
        line_d = line_q;
        if (push_q == IDLE) begin
            if (load) begin
                push_d = PUSH;
                line_d = '0;
            end
        end else if (line_q == LINE_W'(NUM_LINES-1)) begin
            push_d = IDLE;
        end else begin
            line_d = line_q + LINE_W'(1);
        end
    end

    assign push_req  = (push_q == PUSH);
    assign push_data = {line_q, hold_lr_q, hold_q[line_q]};
    assign pop       = s_ready && !fifo_empty;
    assign drop      = push_req && fifo_full;

    always_comb begin
        ovf_d     = ovf_q;
        ovf_cnt_d = ovf_cnt_q;
        if (clr_ovf) begin
            ovf_d     = drop;
            ovf_cnt_d = drop ? 16'd1 : 16'd0;
        end else if (drop) begin
            ovf_d = 1'b1;
            if (ovf_cnt_q != '1) ovf_cnt_d = ovf_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seq_q     <= STOP;
            bit_cnt_q <= '0;
            ws_q      <= 1'b0;
            push_q    <= IDLE;
            line_q    <= '0;
            hold_lr_q <= 1'b0;
            ovf_q     <= 1'b0;
            ovf_cnt_q <= '0;
            for (int unsigned n = 0; n < NUM_LINES; n++) begin
                shift_q[n] <= '0;
                hold_q[n]  <= '0;
            end
        end else begin
            seq_q     <= seq_d;
            bit_cnt_q <= bit_cnt_d;
            ws_q      <= ws_d;
            push_q    <= push_d;
            line_q    <= line_d;
            ovf_q     <= ovf_d;
            ovf_cnt_q <= ovf_cnt_d;
            if (load) hold_lr_q <= slot_lr;
            for (int unsigned n = 0; n < NUM_LINES; n++) begin
                if (shift_en) shift_q[n] <= {shift_q[n][SAMPLE_W-3:0], sd[n]};
                if (load)     hold_q[n]  <= {shift_q[n], sd[n]};
            end
        end
    end

    i2s_sample_fifo #(
        .WIDTH (CHAN_W + SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (reset),
        .push_i      (push_req),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign ws      = ws_q;
    assign busy    = (seq_q == RUN);
    assign s_valid = !fifo_empty;
    assign s_chan  = head[CHAN_W+SAMPLE_W-1:SAMPLE_W];
    assign s_data  = head[SAMPLE_W-1:0];
    assign ovf     = ovf_q;
    assign ovf_cnt = ovf_cnt_q;

endmodule

// File: tb/tb_i2s_mic_capture_ctrl.sv
// Directed bench for i2s_mic_capture_ctrl with a frame-level reference model and an
// expected-sample queue; honours MIC_STEREO_EN the same way as the design.
`timescale 1ns/1ps
module tb_i2s_mic_capture_ctrl;
    import i2s_pkg::*;

    localparam int SAMPLE_W   = DEF_SAMPLE_W;
    localparam int SLOT_W     = DEF_SLOT_W;
    localparam int NUM_LINES  = DEF_NUM_LINES;
    localparam int FIFO_DEPTH = DEF_FIFO_DEPTH;
    localparam int CNT_W      = $clog2(2*SLOT_W);
`ifdef MIC_STEREO_EN
    localparam bit STEREO = 1'b1;
`else
    localparam bit STEREO = 1'b0;
`endif
    localparam int SPF     = STEREO ? 2*NUM_LINES : NUM_LINES;
    localparam int FULL_FR = FIFO_DEPTH / SPF;

    logic                 clk = 1'b0;
    logic                 reset, en, s_ready, clr_ovf;
    logic [NUM_LINES-1:0] sd;
    logic                 ws, busy, s_valid, ovf;
    sample_t              s_data;
    chan_t                s_chan;
    logic [15:0]          ovf_cnt;

    i2s_mic_capture_ctrl #(
        .SAMPLE_W   (SAMPLE_W),
        .SLOT_W     (SLOT_W),
        .NUM_LINES  (NUM_LINES),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .sd      (sd),
        .ws      (ws),
        .busy    (busy),
        .s_data  (s_data),
        .s_chan  (s_chan),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .clr_ovf (clr_ovf),
        .ovf     (ovf),
        .ovf_cnt (ovf_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_pops = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        chan_t   chan;
        sample_t data;
    } entry_t;

    entry_t           exp_q[$];
    logic             m_run;
    logic [CNT_W-1:0] m_cnt;
    int               m_count;
    logic             m_ovf;
    logic [15:0]      m_ovfcnt;
    logic [CNT_W-1:0] m_pos;
    logic             m_lr, m_push, m_full, m_drop, m_pop;
    int               m_line;
    entry_t           m_entry;

    always_comb begin
        m_pos   = (m_cnt >= CNT_W'(SLOT_W)) ? m_cnt - CNT_W'(SLOT_W) : m_cnt;
        m_lr    = (m_cnt >= CNT_W'(SLOT_W));
        m_line  = int'(m_pos) - (SAMPLE_W + 1);
        m_push  = m_run && (int'(m_pos) >= SAMPLE_W + 1) && (int'(m_pos) <= SAMPLE_W + NUM_LINES)
                  && (STEREO || !m_lr);
        m_full  = (m_count == FIFO_DEPTH);
        m_drop  = m_push && m_full;
        m_pop   = (m_count != 0) && s_ready;
        m_entry.chan = chan_t'(m_line * 2 + ((STEREO && m_lr) ? 1 : 0));
        m_entry.data = (m_lr ? 24'h500000 : 24'hA00000) + sample_t'(m_line);
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_run    <= 1'b0;
            m_cnt    <= '0;
            m_count  <= 0;
            m_ovf    <= 1'b0;
            m_ovfcnt <= '0;
            exp_q.delete();
        end else begin
            if (!m_run) begin
                m_cnt <= '0;
                if (en) m_run <= 1'b1;
            end else if (m_cnt == CNT_W'(2*SLOT_W-1)) begin
                m_cnt <= '0;
                if (!en) m_run <= 1'b0;
            end else begin
                m_cnt <= m_cnt + CNT_W'(1);
            end
            if (m_push && !m_full) exp_q.push_back(m_entry);
            m_count <= m_count + ((m_push && !m_full) ? 1 : 0) - (m_pop ? 1 : 0);
            if (clr_ovf) begin
                m_ovf    <= m_drop;
                m_ovfcnt <= m_drop ? 16'd1 : 16'd0;
            end else if (m_drop) begin
                m_ovf <= 1'b1;
                if (m_ovfcnt != 16'hFFFF) m_ovfcnt <= m_ovfcnt + 16'd1;
            end
        end
    end

    // Mic model: line n sends left A00000+n, right 500000+n, MSB one bit after the slot edge.
    always @(negedge clk) begin
        for (int n = 0; n < NUM_LINES; n++) begin
            automatic int      j = int'(m_pos);
            automatic sample_t w = (m_lr ? 24'h500000 : 24'hA00000) + sample_t'(n);
            if (m_run && j >= 1 && j <= SAMPLE_W) sd[n] = w[SAMPLE_W-j];
            else                                  sd[n] = 1'($urandom);
        end
    end

    always @(negedge clk) begin
        #1;
        check("ws", {63'd0, ws}, {63'd0, m_run && m_lr});
        check("busy", {63'd0, busy}, {63'd0, m_run});
        check("s_valid", {63'd0, s_valid}, {63'd0, m_count != 0});
        check("ovf", {63'd0, ovf}, {63'd0, m_ovf});
        check("ovf_cnt", 64'(ovf_cnt), 64'(m_ovfcnt));
        if (s_valid && s_ready) begin
            check("pop_expected", {63'd0, exp_q.size() != 0}, 64'd1);
            if (exp_q.size() != 0) begin
                check("pop_data", 64'(s_data), 64'(exp_q[0].data));
                check("pop_chan", 64'(s_chan), 64'(exp_q[0].chan));
                void'(exp_q.pop_front());
                n_pops++;
            end
        end
    end

    task automatic wait_cnt(input int k);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(m_run && int'(m_cnt) == k) && n < 300);
        check($sformatf("reach_bitcnt_%0d", k), {63'd0, m_run && int'(m_cnt) == k}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    int pops_before;

    initial begin
        reset = 1'b1; en = 1'b0; s_ready = 1'b0; clr_ovf = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_ws", {63'd0, ws}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_s_valid", {63'd0, s_valid}, 64'd0);
        check("rst_s_data", 64'(s_data), 64'd0);
        check("rst_s_chan", 64'(s_chan), 64'd0);
        check("rst_ovf_cnt", 64'(ovf_cnt), 64'd0);

        // Free-running capture with an always-ready consumer
        @(negedge clk);
        reset = 1'b0; s_ready = 1'b1; en = 1'b1;
        wait_cnt(63);
        wait_cnt(63);
        check("frames2_pops", 64'(n_pops), 64'(2*SPF));
        check("frames2_q_empty", 64'(exp_q.size()), 64'd0);

        // ws edges and first left push timing
        wait_cnt(31);
        #1 check("ws_at_31", {63'd0, ws}, 64'd0);
        wait_cnt(32);
        #1 check("ws_at_32", {63'd0, ws}, 64'd1);
        wait_cnt(25);
        #1 check("empty_at_25", {63'd0, s_valid}, 64'd0);
        @(negedge clk);
        #1;
        check("valid_at_26", {63'd0, s_valid}, 64'd1);
        check("head_chan_26", 64'(s_chan), 64'd0);
        check("head_data_26", 64'(s_data), 64'hA00000);

        // Back-pressure: fill, then one frame of drops, then clear
        wait_cnt(0);
        s_ready = 1'b0;
        repeat (FULL_FR) wait_cnt(63);
        #1;
        check("full_valid", {63'd0, s_valid}, 64'd1);
        check("full_no_ovf", {63'd0, ovf}, 64'd0);
        wait_cnt(63);
        #1;
        check("drop_ovf", {63'd0, ovf}, 64'd1);
        check("drop_ovf_cnt", 64'(ovf_cnt), 64'(SPF));
        wait_cnt(1);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        #1;
        check("clr_ovf", {63'd0, ovf}, 64'd0);
        check("clr_ovf_cnt", 64'(ovf_cnt), 64'd0);

        // Pop while full during a push cycle: push refused, head still popped
        wait_cnt(25);
        s_ready = 1'b1;
        @(negedge clk);
        s_ready = 1'b0;
        #1;
        check("popfull_ovf_cnt", 64'(ovf_cnt), 64'd1);
        check("popfull_ovf", {63'd0, ovf}, 64'd1);
        @(negedge clk);
        s_ready = 1'b1;
        wait_cnt(63);
        wait_cnt(63);
        #1 check("drained", {63'd0, s_valid}, 64'd0);

        // en dropped mid-frame: frame completes, samples stay poppable in STOP
        wait_cnt(10);
        en = 1'b0; s_ready = 1'b0;
        pops_before = n_pops;
        wait_cnt(63);
        #1 check("stop_busy_63", {63'd0, busy}, 64'd1);
        @(negedge clk);
        #1;
        check("stop_busy", {63'd0, busy}, 64'd0);
        check("stop_ws", {63'd0, ws}, 64'd0);
        check("stop_valid", {63'd0, s_valid}, 64'd1);
        repeat (5) @(negedge clk);
        s_ready = 1'b1;
        repeat (SPF + 4) @(negedge clk);
        #1;
        check("stop_pops", 64'(n_pops - pops_before), 64'(SPF));
        check("stop_drained", {63'd0, s_valid}, 64'd0);

        // Async reset mid-frame with five samples queued
        @(negedge clk);
        en = 1'b1; s_ready = 1'b0;
        wait_cnt(61);
        s_ready = 1'b1;
        repeat (SPF - 1) @(negedge clk);
        s_ready = 1'b0;
        wait_cnt(40);
        #1;
        check("pre_rst_ws", {63'd0, ws}, 64'd1);
        check("pre_rst_q", 64'(exp_q.size()), 64'd5);
        #1;
        reset = 1'b1;
        #1;
        check("arst_s_valid", {63'd0, s_valid}, 64'd0);
        check("arst_ws", {63'd0, ws}, 64'd0);
        check("arst_busy", {63'd0, busy}, 64'd0);
        check("arst_ovf_cnt", 64'(ovf_cnt), 64'd0);
        check("arst_s_data", 64'(s_data), 64'd0);
        @(negedge clk);
        reset = 1'b0; en = 1'b0;
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
